// File: rtl/mdu_pkg.sv
// Op encodings and shared decode helpers for the multiply/divide unit.
// MADD/MADDU/MSUB/MSUBU count as start ops only when MDU_MADD_EN is defined.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  localparam int MD_W = 32;

  // Shared with the hazard unit: stall on (busy | is_md_start(ex_op)).
  function automatic logic is_md_start(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: is_md_start = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: is_md_start = 1'b1;
`endif
      default: is_md_start = 1'b0;
    endcase
  endfunction

  function automatic logic is_md_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: full 64-bit {HI,LO} result from op, a, b.
// Zero latency; res_vld is low for divide by zero and for non-start ops. MDU_MADD_EN adds MADD*/MSUB*.
// No flow control: consumer samples res/res_vld on its accepting edge.
module md_calc
  import mdu_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [MD_W-1:0]   a,
  input  logic [MD_W-1:0]   b,
  input  logic [2*MD_W-1:0] hilo,
  output logic [2*MD_W-1:0] res,
  output logic              res_vld
);

  logic [2*MD_W-1:0] prod_s;
  logic [2*MD_W-1:0] prod_u;
  logic [MD_W-1:0]   mag_a;
  logic [MD_W-1:0]   mag_b;
  logic [MD_W-1:0]   dvd;
  logic [MD_W-1:0]   dvs;
  logic [MD_W-1:0]   q_u;
  logic [MD_W-1:0]   r_u;
  logic [MD_W-1:0]   q_s;
  logic [MD_W-1:0]   r_s;

  // A 64x64 multiply of the sign-extended operands is the exact signed product mod 2^64.
  assign prod_s = {{MD_W{a[MD_W-1]}}, a} * {{MD_W{b[MD_W-1]}}, b};
  assign prod_u = {{MD_W{1'b0}}, a} * {{MD_W{1'b0}}, b};

  // One unsigned divider serves both DIV (on magnitudes) and DIVU.
  assign mag_a = a[MD_W-1] ? (~a + 1'b1) : a;
  assign mag_b = b[MD_W-1] ? (~b + 1'b1) : b;
  assign dvd   = (op == MD_DIV) ? mag_a : a;
  assign dvs   = (b == '0) ? {{(MD_W-1){1'b0}}, 1'b1} : ((op == MD_DIV) ? mag_b : b);
  assign q_u   = dvd / dvs;
  assign r_u   = dvd % dvs;

  // Truncating division: quotient negative on sign mismatch, remainder follows the dividend.
  assign q_s = (a[MD_W-1] ^ b[MD_W-1]) ? (~q_u + 1'b1) : q_u;
  assign r_s = a[MD_W-1] ? (~r_u + 1'b1) : r_u;

  always_comb begin
    res     = '0;
    res_vld = 1'b0;
    case (op)
      MD_MULT: begin
        res     = prod_s;
        res_vld = 1'b1;
      end
      MD_MULTU: begin
        res     = prod_u;
        res_vld = 1'b1;
      end
      MD_DIV: begin
        res     = {r_s, q_s};
        res_vld = (b != '0);
      end
      MD_DIVU: begin
        res     = {r_u, q_u};
        res_vld = (b != '0);
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        res     = hilo + prod_s;
        res_vld = 1'b1;
      end
      MD_MADDU: begin
        res     = hilo + prod_u;
        res_vld = 1'b1;
      end
      MD_MSUB: begin
        res     = hilo - prod_s;
        res_vld = 1'b1;
      end
      MD_MSUBU: begin
        res     = hilo - prod_u;
        res_vld = 1'b1;
      end
`endif
      default: begin
        res     = '0;
        res_vld = 1'b0;
      end
    endcase
  end

`ifndef MDU_MADD_EN
  logic unused_hilo;
  assign unused_hilo = ^hilo;
`endif

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO; MDU_MADD_EN enables MADD*/MSUB*.
// Latency: MULT_CYCLES / DIV_CYCLES of busy after the accepting edge, HI/LO update as busy falls.
// Backpressure: start ops and MT* are dropped while busy; the hazard unit stalls on busy.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      md_op,
  input  logic [MD_W-1:0] md_a,
  input  logic [MD_W-1:0] md_b,
  input  logic            rd_sel,
  output logic            busy,
  output logic [MD_W-1:0] md_rd
);

  localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  load_val;
  logic [2*MD_W-1:0] pend;
  logic              pend_vld;
  logic [MD_W-1:0]   hi;
  logic [MD_W-1:0]   lo;
  logic [2*MD_W-1:0] calc_res;
  logic              calc_vld;

  md_calc u_calc (
    .op      (md_op),
    .a       (md_a),
    .b       (md_b),
    .hilo    ({hi, lo}),
    .res     (calc_res),
    .res_vld (calc_vld)
  );

  assign load_val = is_md_div(md_op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

  // Result is computed at acceptance and parked in pend; HI/LO only ever see final values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        ST_BUSY: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            if (pend_vld) begin
              hi <= pend[2*MD_W-1:MD_W];
              lo <= pend[MD_W-1:0];
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          if (is_md_start(md_op)) begin
            state    <= ST_BUSY;
            cnt      <= load_val;
            pend     <= calc_res;
            pend_vld <= calc_vld;
          end else if (md_op == MD_MTHI) begin
            hi <= md_a;
          end else if (md_op == MD_MTLO) begin
            lo <= md_a;
          end
        end
      endcase
    end
  end

  assign busy  = (state == ST_BUSY);
  assign md_rd = rd_sel ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [3:0]  md_op  = 4'd0;
  logic [31:0] md_a   = '0;
  logic [31:0] md_b   = '0;
  logic        rd_sel = 1'b0;
  logic        busy;
  logic [31:0] md_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          m_left;
  logic [63:0] m_pend;
  bit          m_pend_ok;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .md_op  (md_op),
    .md_a   (md_a),
    .md_b   (md_b),
    .rd_sel (rd_sel),
    .busy   (busy),
    .md_rd  (md_rd)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit tb_is_start(input logic [3:0] op);
    if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MDU_MADD_EN
    if (op >= 4'd7 && op <= 4'd10) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_left = 0; m_pend = '0; m_pend_ok = 1'b0;
  endtask

  task automatic model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [63:0] r, output bit ok);
    longint      sa, sb, q, rm;
    logic [63:0] acc, ps, pu;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {m_hi, m_lo};
    ps  = sa * sb;
    pu  = {32'b0, a} * {32'b0, b};
    r   = acc;
    ok  = 1'b1;
    case (op)
      4'd1: r = ps;
      4'd2: r = pu;
      4'd3: if (b == 0) ok = 1'b0;
            else begin q = sa / sb; rm = sa % sb; r = {rm[31:0], q[31:0]}; end
      4'd4: if (b == 0) ok = 1'b0;
            else r = {a % b, a / b};
      4'd7: r = acc + ps;
      4'd8: r = acc + pu;
      4'd9: r = acc - ps;
      4'd10: r = acc - pu;
      default: ok = 1'b0;
    endcase
  endtask

  task automatic model_edge(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pend_ok) {m_hi, m_lo} = m_pend;
    end else if (tb_is_start(op)) begin
      model_result(op, a, b, m_pend, m_pend_ok);
      m_left = (op == 4'd3 || op == 4'd4) ? DC : MC;
    end else if (op == 4'd5) begin
      m_hi = a;
    end else if (op == 4'd6) begin
      m_lo = a;
    end
  endtask

  // Drive one op for one cycle, compare outputs with the model, then advance both.
  task automatic cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    md_op = op; md_a = a; md_b = b;
    rd_sel = 1'b0; #1;
    chk_eq({tag, ".lo"}, 64'(md_rd), 64'(m_lo));
    rd_sel = 1'b1; #1;
    chk_eq({tag, ".hi"}, 64'(md_rd), 64'(m_hi));
    chk_eq({tag, ".busy"}, 64'(busy), 64'(m_left > 0));
    @(posedge clk);
    model_edge(op, a, b);
    #1;
  endtask

  task automatic expect_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    rd_sel = 1'b1; #1;
    chk_eq({tag, ".HI"}, 64'(md_rd), 64'(eh));
    rd_sel = 1'b0; #1;
    chk_eq({tag, ".LO"}, 64'(md_rd), 64'(el));
  endtask

  // Issue NOPs while busy (bounded) and check how many busy cycles remained.
  task automatic drain(input string tag, input int exp_cycles);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      n++;
      cycle(MD_NOP, 32'h0, 32'h0, {tag, ".drain"});
    end
    chk_eq({tag, ".busy_cycles"}, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    model_reset();
    #12;
    chk_eq("rst.busy", 64'(busy), 64'd0);
    expect_hilo("rst", 32'h0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    cycle(MD_MULT, 32'hFFFF_FFFE, 32'd3, "t1");
    drain("t1", MC);
    expect_hilo("t1", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    cycle(MD_DIV, 32'hFFFF_FFF9, 32'd2, "t2s");
    drain("t2s", DC);
    expect_hilo("t2s", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    cycle(MD_DIVU, 32'd7, 32'd2, "t2u");
    drain("t2u", DC);
    expect_hilo("t2u", 32'd1, 32'd3);
    cycle(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "t2ovf");
    drain("t2ovf", DC);
    expect_hilo("t2ovf", 32'h0, 32'h8000_0000);

    cycle(MD_MTHI, 32'h11, 32'h0, "t3");
    cycle(MD_MTLO, 32'h22, 32'h0, "t3");
    cycle(MD_DIVU, 32'd5, 32'd0, "t3");
    drain("t3", DC);
    expect_hilo("t3", 32'h11, 32'h22);

    cycle(MD_MULT, 32'd3, 32'd4, "t4");
    cycle(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t4");
    cycle(MD_MTLO, 32'd5, 32'h0, "t4");
    drain("t4", MC - 2);
    expect_hilo("t4", 32'h0, 32'd12);
    cycle(MD_MTHI, 32'hABCD, 32'h0, "t4");
    chk_eq("t4.mthi_busy", 64'(busy), 64'd0);
    expect_hilo("t4.mthi", 32'hABCD, 32'd12);

    cycle(MD_DIV, 32'd100, 32'd7, "t5");
    cycle(MD_NOP, 32'h0, 32'h0, "t5");
    cycle(MD_NOP, 32'h0, 32'h0, "t5");
    rst_n = 1'b0; #1;
    model_reset();
    chk_eq("t5.rst_busy", 64'(busy), 64'd0);
    expect_hilo("t5.rst", 32'h0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(MD_MULTU, 32'h0001_0000, 32'h0001_0000, "t5.after");
    drain("t5.after", MC);
    expect_hilo("t5.after", 32'd1, 32'd0);

    cycle(MD_MTHI, 32'h0, 32'h0, "t6");
    cycle(MD_MTLO, 32'hFFFF_FFFF, 32'h0, "t6");
    cycle(MD_MADDU, 32'd1, 32'd1, "t6");
`ifdef MDU_MADD_EN
    drain("t6", MC);
    expect_hilo("t6", 32'd1, 32'd0);
`else
    drain("t6", 0);
    expect_hilo("t6", 32'd0, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if (busy === 1'b0 && $urandom_range(0, 2) == 0) op = 4'($urandom_range(1, 4));
      cycle(op, a, b, "rnd");
    end
    drain("rnd.end", m_left);
    expect_hilo("rnd.end", m_hi, m_lo);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
